// File: rtl/carbon_core_p.sv
// carbon_core_p: small accumulator processor with a two-cycle fetch/execute loop.
// It has valid/ready input and output ports and a bounded return-address stack.
// Any fault, such as an illegal opcode or a stack overflow or underflow, parks the
// core in HALT with err set. Only reset leaves HALT.
module carbon_core_p #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   pc_o,
    input  logic [DATA_W+3:0] inst,
    input  logic [DATA_W-1:0] di,
    input  logic              di_valid,
    output logic              di_ready,
    output logic [DATA_W-1:0] do_o,
    output logic              do_valid,
    input  logic              do_ready,
    output logic              halted,
    output logic              err
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JN   = 4'hB;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_WAIT_IN,
        S_WAIT_OUT,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W+3:0]   ir_q, ir_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [PC_W-1:0]     stack_q [STACK_DEPTH];
    logic [PC_W-1:0]     stack_d [STACK_DEPTH];
    logic [DATA_W-1:0]   do_q, do_d;
    logic                do_valid_q, do_valid_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;

    logic [3:0]          op;
    logic [DATA_W-1:0]   imm;
    logic [PC_W-1:0]     target;
    logic [PC_W-1:0]     pc_inc;
    logic                zero_flag;
    logic                neg_flag;
    logic                stack_full;
    logic                stack_empty;
    logic [PC_W-1:0]     stack_top;

    // Decode fields of the held instruction, and derive the flags and stack status.
    always_comb begin
        op          = ir_q[DATA_W+3:DATA_W];
        imm         = ir_q[DATA_W-1:0];
        target      = imm[PC_W-1:0];
        pc_inc      = pc_q + PC_W'(1);
        zero_flag   = (acc_q == '0);
        neg_flag    = acc_q[DATA_W-1];
        stack_full  = (sp_q == SP_W'(STACK_DEPTH));
        stack_empty = (sp_q == '0);
        stack_top   = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    // Next-state logic: every register holds unless the current state and opcode update it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        ir_d       = ir_q;
        sp_d       = sp_q;
        stack_d    = stack_q;
        do_d       = do_q;
        do_valid_d = do_valid_q;
        halted_d   = halted_q;
        err_d      = err_q;
        di_ready   = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_d    = inst;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_NOP:  ;
                    OP_LDI:  acc_d = imm;
                    OP_ADDI: acc_d = acc_q + imm;
                    OP_SUBI: acc_d = acc_q - imm;
                    OP_ANDI: acc_d = acc_q & imm;
                    OP_ORI:  acc_d = acc_q | imm;
                    OP_XORI: acc_d = acc_q ^ imm;
                    OP_IN: begin
                        di_ready = 1'b1;
                        if (di_valid) begin
                            acc_d = di;
                        end else begin
                            pc_d    = pc_q;
                            state_d = S_WAIT_IN;
                        end
                    end
                    OP_OUT: begin
                        do_d       = acc_q;
                        do_valid_d = 1'b1;
                        pc_d       = pc_q;
                        state_d    = S_WAIT_OUT;
                    end
                    OP_JMP: pc_d = target;
                    OP_JZ: begin
                        if (zero_flag) begin
                            pc_d = target;
                        end
                    end
                    OP_JN: begin
                        if (neg_flag) begin
                            pc_d = target;
                        end
                    end
                    OP_CALL: begin
                        if (stack_full) begin
                            pc_d     = pc_q;
                            halted_d = 1'b1;
                            err_d    = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            for (int i = 0; i < STACK_DEPTH; i++) begin
                                if (sp_q == SP_W'(i)) begin
                                    stack_d[i] = pc_inc;
                                end
                            end
                            sp_d = sp_q + SP_W'(1);
                            pc_d = target;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            pc_d     = pc_q;
                            halted_d = 1'b1;
                            err_d    = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            pc_d = stack_top;
                            sp_d = sp_q - SP_W'(1);
                        end
                    end
                    OP_HALT: begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                        err_d    = 1'b0;
                        state_d  = S_HALT;
                    end
                    default: begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                        err_d    = 1'b1;
                        state_d  = S_HALT;
                    end
                endcase
            end

            S_WAIT_IN: begin
                di_ready = 1'b1;
                if (di_valid) begin
                    acc_d   = di;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_WAIT_OUT: begin
                if (do_ready) begin
                    do_valid_d = 1'b0;
                    pc_d       = pc_inc;
                    state_d    = S_FETCH;
                end
            end

            S_HALT: ;

            default: state_d = S_FETCH;
        endcase
    end

    // Architectural registers, with a synchronous active-low reset that overrides everything else.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            acc_q      <= '0;
            ir_q       <= '0;
            sp_q       <= '0;
            do_q       <= '0;
            do_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            ir_q       <= ir_d;
            sp_q       <= sp_d;
            do_q       <= do_d;
            do_valid_q <= do_valid_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    // Stack contents need no reset; SP going to zero makes every stale entry unreachable.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc_o     = pc_q;
    assign do_o     = do_q;
    assign do_valid = do_valid_q;
    assign halted   = halted_q;
    assign err      = err_q;

endmodule

// File: tb/tb_carbon_core_p.sv
// tb_carbon_core_p: directed program vectors plus handshake and reset sequences for carbon_core_p.
module tb_carbon_core_p;

    localparam logic [11:0] H = 12'hE00;

    typedef struct {
        string             name;
        logic [0:11][11:0] prog;
        logic [7:0]        exp_pc;
        logic              exp_err;
        logic [7:0]        exp_do;
    } tvec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pc_o;
    logic [11:0] inst;
    logic [7:0]  di = '0;
    logic        di_valid = 1'b0;
    logic        di_ready;
    logic [7:0]  do_o;
    logic        do_valid;
    logic        do_ready = 1'b0;
    logic        halted;
    logic        err;

    logic [11:0] mem [256];
    tvec_t       vecs [$];
    int          total = 0;
    int          bad = 0;

    assign inst = mem[pc_o];

    carbon_core_p #(.DATA_W(8), .PC_W(8), .STACK_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc_o(pc_o), .inst(inst),
        .di(di), .di_valid(di_valid), .di_ready(di_ready),
        .do_o(do_o), .do_valid(do_valid), .do_ready(do_ready),
        .halted(halted), .err(err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_prog(input logic [0:11][11:0] p);
        for (int i = 0; i < 256; i++) mem[i] = H;
        for (int i = 0; i < 12; i++) mem[i] = p[i];
    endtask

    task automatic apply_stimulus();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic add_vec(input string nm, input logic [0:11][11:0] p,
                           input logic [7:0] epc, input logic eerr, input logic [7:0] edo);
        tvec_t v;
        v.name    = nm;
        v.prog    = p;
        v.exp_pc  = epc;
        v.exp_err = eerr;
        v.exp_do  = edo;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("add_wrap",   {12'h105, 12'h2FA, 12'hA10, 12'h800, 12'hE00, {7{H}}}, 8'd4, 1'b0, 8'hFF);
        add_vec("jn_jz_take", {12'h180, 12'hB04, 12'hF00, 12'hF00, 12'h280, 12'hA07, 12'hF00,
                               12'h800, 12'hE00, {3{H}}}, 8'd8, 1'b0, 8'h00);
        add_vec("logic_ops",  {12'h10F, 12'h310, 12'h43C, 12'h541, 12'h6FF, 12'h800, 12'hE00,
                               {5{H}}}, 8'd6, 1'b0, 8'h82);
        add_vec("br_not",     {12'h101, 12'hB05, 12'hA05, 12'h800, 12'hE00, 12'hF00, {6{H}}},
                               8'd4, 1'b0, 8'h01);
        add_vec("call_ret",   {12'h107, 12'hC05, 12'h800, 12'hE00, 12'hF00, 12'h201, 12'hC09,
                               12'hD00, 12'hF00, 12'h6F0, 12'hD00, H}, 8'd3, 1'b0, 8'hF8);
        add_vec("illegal",    {12'h13C, 12'h800, 12'hF00, {9{H}}}, 8'd2, 1'b1, 8'h3C);
        add_vec("ret_empty",  {12'hD00, {11{H}}}, 8'd0, 1'b1, 8'h00);
        add_vec("nop_jmp",    {12'h000, 12'h904, 12'hF00, 12'hF00, 12'h199, 12'h800, 12'hE00,
                               {5{H}}}, 8'd6, 1'b0, 8'h99);
        add_vec("call_ovf",   {12'hC01, 12'hC02, 12'hC03, {9{H}}}, 8'd2, 1'b1, 8'h00);

        // Reset values, then exact cycle timing of the reference program.
        load_prog({12'h105, 12'h2FA, 12'hA10, 12'hE00, {8{H}}});
        apply_stimulus();
        check_output("rst_pc", pc_o, 0);
        check_output("rst_halted", halted, 0);
        check_output("rst_err", err, 0);
        check_output("rst_do", do_o, 0);
        check_output("rst_do_valid", do_valid, 0);
        check_output("rst_di_ready", di_ready, 0);
        for (int i = 0; i < 7; i++) step();
        check_output("ref_c7_halted", halted, 0);
        check_output("ref_c7_pc", pc_o, 3);
        step();
        check_output("ref_c8_halted", halted, 1);
        check_output("ref_c8_err", err, 0);
        check_output("ref_c8_pc", pc_o, 3);

        // Taken JN to 0x20, then an ADDI that wraps to zero so JZ is taken.
        for (int i = 0; i < 256; i++) mem[i] = H;
        mem[0] = 12'h180; mem[1] = 12'hB20;
        mem[8'h20] = 12'h280; mem[8'h21] = 12'hA30;
        mem[8'h30] = 12'h800;
        do_ready = 1'b1;
        apply_stimulus();
        for (int i = 0; i < 4; i++) step();
        check_output("jn_target_pc", pc_o, 8'h20);
        run_until_halt(100);
        check_output("jz_wrap_pc", pc_o, 8'h31);
        check_output("jz_wrap_do", do_o, 8'h00);

        // Table of whole programs, each run to HALT; a few extra idle cycles confirm the halt is frozen.
        foreach (vecs[k]) begin
            load_prog(vecs[k].prog);
            do_ready = 1'b1;
            di_valid = 1'b0;
            apply_stimulus();
            run_until_halt(200);
            for (int i = 0; i < 3; i++) step();
            check_output({vecs[k].name, "_pc"}, pc_o, vecs[k].exp_pc);
            check_output({vecs[k].name, "_halted"}, halted, 1);
            check_output({vecs[k].name, "_err"}, err, vecs[k].exp_err);
            check_output({vecs[k].name, "_do"}, do_o, vecs[k].exp_do);
            check_output({vecs[k].name, "_do_valid"}, do_valid, 0);
        end

        // IN with di_valid held low for three cycles: di_ready is seen for four cycles and one word is taken.
        load_prog({12'h700, 12'h800, 12'hE00, {9{H}}});
        di_valid = 1'b0;
        do_ready = 1'b1;
        apply_stimulus();
        step();
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("in_ready_%0d", k), di_ready, 1);
            check_output($sformatf("in_pc_%0d", k), pc_o, 0);
            di_valid = (k == 3);
            di = 8'h3C;
            step();
        end
        di_valid = 1'b0;
        check_output("in_done_ready", di_ready, 0);
        check_output("in_done_pc", pc_o, 1);
        run_until_halt(50);
        check_output("in_acc_out", do_o, 8'h3C);
        check_output("in_end_pc", pc_o, 2);

        // OUT of 0xA5 with do_ready low for two cycles. A high do_ready before WAIT_OUT must be ignored.
        load_prog({12'h1A5, 12'h800, 12'hE00, {9{H}}});
        do_ready = 1'b1;
        apply_stimulus();
        for (int i = 0; i < 4; i++) step();
        do_ready = 1'b0;
        check_output("out_v1", do_valid, 1);
        check_output("out_data", do_o, 8'hA5);
        step();
        check_output("out_v2", do_valid, 1);
        step();
        check_output("out_v3", do_valid, 1);
        check_output("out_wait_pc", pc_o, 1);
        do_ready = 1'b1;
        step();
        check_output("out_drop", do_valid, 0);
        check_output("out_pc", pc_o, 2);
        check_output("out_hold", do_o, 8'hA5);

        // Reset asserted while in WAIT_OUT aborts the transfer.
        do_ready = 1'b0;
        apply_stimulus();
        for (int i = 0; i < 5; i++) step();
        check_output("wo_pre_valid", do_valid, 1);
        rst = 1'b0;
        step();
        check_output("wo_rst_pc", pc_o, 0);
        check_output("wo_rst_valid", do_valid, 0);
        check_output("wo_rst_do", do_o, 0);
        check_output("wo_rst_halted", halted, 0);
        rst = 1'b1;

        // Reset asserted while in WAIT_IN drops di_ready, and the core restarts cleanly.
        load_prog({12'h700, 12'h800, 12'hE00, {9{H}}});
        di_valid = 1'b0;
        apply_stimulus();
        step();
        step();
        check_output("wi_pre_ready", di_ready, 1);
        rst = 1'b0;
        di_valid = 1'b1;
        di = 8'h77;
        step();
        check_output("wi_rst_ready", di_ready, 0);
        check_output("wi_rst_pc", pc_o, 0);
        di_valid = 1'b0;
        rst = 1'b1;
        step();
        di_valid = 1'b1;
        di = 8'h11;
        do_ready = 1'b1;
        run_until_halt(50);
        check_output("wi_after_do", do_o, 8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/carbon_core_p.md
CARBON_CORE_P -- requirements
Module: carbon_core_p

Interface
REQ-001 Parameter DATA_W, 8, accumulator/data/immediate width; SHALL be >= PC_W.
REQ-002 Parameter PC_W, 8, program counter width.
REQ-003 Parameter STACK_DEPTH, 4, return-address stack entries (>= 1).
REQ-004 clk  input  1  sole clock; all state SHALL change on rising edge only.
REQ-005 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 pc_o  output  PC_W  registered program counter (instruction memory address).
REQ-007 inst  input  4+DATA_W  instruction; [DATA_W+3:DATA_W] = OP, [DATA_W-1:0] = C; combinational memory, valid in the cycle pc_o is presented.
REQ-008 di  input  DATA_W  input data word.
REQ-009 di_valid  input  1  di holds valid data.
REQ-010 di_ready  output  1  core accepts di this cycle.
REQ-011 do  output  DATA_W  registered output data word; holds its last value.
REQ-012 do_valid  output  1  registered; do holds a word to be taken.
REQ-013 do_ready  input  1  consumer takes do this cycle.
REQ-014 halted  output  1  registered; core stopped; only reset exits.
REQ-015 err  output  1  registered; halt caused by fault.

Function
REQ-016 FSM states: FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT; one instruction = FETCH + EXEC (2 cycles) plus handshake wait cycles.
REQ-017 FETCH: IR <= inst; next state EXEC; PC unchanged.
REQ-018 In EXEC, OP from IR SHALL be: 0 NOP; 1 LDI ACC=C; 2 ADDI ACC=ACC+C; 3 SUBI ACC=ACC-C; 4 ANDI; 5 ORI; 6 XORI; 7 IN; 8 OUT; 9 JMP; A JZ; B JN; C CALL; D RET; E HALT; F illegal.
REQ-019 Arithmetic modulo 2^DATA_W, no carry/overflow retained; Z = (ACC==0), N = ACC[DATA_W-1], both combinational from current ACC.
REQ-020 Non-branch ops SHALL set PC <= PC+1 (modulo 2^PC_W, wrap from all-ones to 0) and return to FETCH.
REQ-021 JMP: PC <= C[PC_W-1:0]; JZ/JN: same target if Z/N set, else PC+1.
REQ-022 CALL: if stack not full, push PC+1, SP+1, PC <= C[PC_W-1:0]; if full, HALT with err=1, PC and stack unchanged.
REQ-023 RET: if stack not empty, PC <= top, SP-1; if empty, HALT with err=1.
REQ-024 IN: di_ready=1 (combinational) in EXEC and WAIT_IN; when di_valid && di_ready, ACC <= di, PC+1, FETCH; else go/stay WAIT_IN; ACC unchanged while waiting.
REQ-025 OUT (EXEC): do <= ACC, do_valid <= 1, go WAIT_OUT; in WAIT_OUT, on do_ready, do_valid <= 0, PC+1, FETCH; do_ready outside WAIT_OUT is ignored.
REQ-026 di_ready SHALL be 0 in all states other than EXEC-with-IN and WAIT_IN.
REQ-027 HALT (OP E): halted <= 1, err <= 0; OP F: halted <= 1, err <= 1; PC frozen at the halting instruction.
REQ-028 In HALT state no register other than via reset SHALL change; di_ready=0, do_valid=0.
REQ-029 Stack SP range 0..STACK_DEPTH; full when SP==STACK_DEPTH, empty when SP==0.

Reset
REQ-030 rst low at rising clk: PC=0, ACC=0, IR=0, SP=0, do=0, do_valid=0, halted=0, err=0, state FETCH; takes priority over all operations.
REQ-031 Reset during WAIT_IN/WAIT_OUT SHALL abort the handshake; do_valid=0 and di_ready=0 the cycle after the reset edge; no di word consumed at that edge.

Verification
REQ-032 Program LDI 5; ADDI 250; JZ 0x10; HALT at default widths -> ACC=255, JZ not taken, halted=1 err=0, pc_o=3 after 8 cycles.
REQ-033 LDI 0x80; JN 0x20 -> pc_o=0x20; ADDI 0x80 -> ACC=0 (wrap), Z=1.
REQ-034 IN with di_valid low 3 cycles then di=0x3C high -> di_ready high 4 cycles, ACC=0x3C, PC+1, one transfer only.
REQ-035 OUT with ACC=0xA5, do_ready low 2 cycles -> do=0xA5, do_valid held 3 cycles, drops after do_ready, PC+1.
REQ-036 STACK_DEPTH=2: CALL,CALL,CALL -> third CALL halts err=1, pc_o at third CALL; separately RET on empty -> err=1.
REQ-037 rst asserted in WAIT_OUT -> next cycle pc_o=0, do_valid=0, do=0, halted=0.
